// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control FSM and its environment (buttons, tick divider, datapath).
// The control block uses the master modport; the environment side uses slave.
interface stopwatch_ctrl_if;
  logic       btn_pause;
  logic       btn_rst;
  logic       sw_adj;
  logic       sw_sel;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       tick_blink;
  logic [5:0] sec_val;
  logic       hold;
  logic       clr;
  logic       inc_sec;
  logic       inc_min;
  logic       blank_sec;
  logic       blank_min;
  logic [1:0] state_o;

  modport master (
    input  btn_pause, btn_rst, sw_adj, sw_sel, tick_1hz, tick_2hz, tick_blink, sec_val,
    output hold, clr, inc_sec, inc_min, blank_sec, blank_min, state_o
  );

  modport slave (
    output btn_pause, btn_rst, sw_adj, sw_sel, tick_1hz, tick_2hz, tick_blink, sec_val,
    input  hold, clr, inc_sec, inc_min, blank_sec, blank_min, state_o
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the mm:ss stopwatch: button conditioning, run/pause/adjust sequencing,
// registered increment/clear pulses and adjust-mode digit blinking.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ADJ   = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_btn_s1;
  logic [1:0]      r_btn_s2;
  logic [1:0]      r_btn_db;
  logic [1:0]      r_btn_db_d;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      r_adj_s;
  logic [1:0]      r_sel_s;
  logic            r_hold;
  logic            r_clr;
  logic            r_inc_sec;
  logic            r_inc_min;
  logic            r_phase;
  logic            r_blank_sec;
  logic            r_blank_min;

  logic [1:0]      w_btn_raw;
  logic [1:0]      w_press;
  logic            w_pause_ev;
  logic            w_clr_ev;
  logic            w_adj;
  logic            w_sel;
  logic            w_clr_nxt;
  logic            w_inc_sec_nxt;
  logic            w_inc_min_nxt;
  logic            w_phase_nxt;

  // Bit 0 is the pause button, bit 1 the clear button.
  assign w_btn_raw  = {bus.btn_rst, bus.btn_pause};
  assign w_press    = r_btn_db & ~r_btn_db_d;
  assign w_pause_ev = w_press[0];
  assign w_clr_ev   = w_press[1];
  assign w_adj      = r_adj_s[1];
  assign w_sel      = r_sel_s[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_db   <= '0;
      r_btn_db_d <= '0;
      r_adj_s    <= '0;
      r_sel_s    <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_btn_s1   <= w_btn_raw;
      r_btn_s2   <= r_btn_s1;
      r_btn_db_d <= r_btn_db;
      r_adj_s    <= {r_adj_s[0], bus.sw_adj};
      r_sel_s    <= {r_sel_s[0], bus.sw_sel};
      // A level is accepted only after DB_CYCLES consecutive differing samples.
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          r_btn_db[i] <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_nxt     = 1'b0;
    w_inc_sec_nxt = 1'b0;
    w_inc_min_nxt = 1'b0;
    w_phase_nxt   = 1'b0;

    // Clear press outranks an adjust-switch change, which outranks a pause press.
    case (r_state)
      ST_STOP: begin
        if (w_clr_ev)        w_clr_nxt   = 1'b1;
        else if (w_adj)      w_state_nxt = ST_ADJ;
        else if (w_pause_ev) w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (w_clr_ev) begin
          w_state_nxt = ST_STOP;
          w_clr_nxt   = 1'b1;
        end else if (w_adj) begin
          w_state_nxt = ST_ADJ;
        end else if (w_pause_ev) begin
          w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
      end
      ST_ADJ: begin
        if (w_clr_ev)   w_clr_nxt   = 1'b1;
        else if (!w_adj) w_state_nxt = ST_PAUSE;
      end
      default: w_state_nxt = ST_STOP;
    endcase

    // Ticks follow the rule of the state they arrive in and never coincide with a clear.
    if (!w_clr_nxt) begin
      if (r_state == ST_RUN) begin
        w_inc_sec_nxt = bus.tick_1hz;
        w_inc_min_nxt = bus.tick_1hz && (bus.sec_val == 6'd59);
      end else if (r_state == ST_ADJ && bus.tick_2hz) begin
        w_inc_sec_nxt = w_sel;
        w_inc_min_nxt = !w_sel;
      end
    end

    if (r_state == ST_ADJ && w_state_nxt == ST_ADJ) w_phase_nxt = r_phase ^ bus.tick_blink;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_STOP;
      r_hold      <= 1'b1;
      r_clr       <= 1'b0;
      r_inc_sec   <= 1'b0;
      r_inc_min   <= 1'b0;
      r_phase     <= 1'b0;
      r_blank_sec <= 1'b0;
      r_blank_min <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= (w_state_nxt != ST_RUN);
      r_clr       <= w_clr_nxt;
      r_inc_sec   <= w_inc_sec_nxt;
      r_inc_min   <= w_inc_min_nxt;
      r_phase     <= w_phase_nxt;
      r_blank_sec <= w_phase_nxt & w_sel;
      r_blank_min <= w_phase_nxt & ~w_sel;
    end
  end

  assign bus.state_o   = r_state;
  assign bus.hold      = r_hold;
  assign bus.clr       = r_clr;
  assign bus.inc_sec   = r_inc_sec;
  assign bus.inc_min   = r_inc_min;
  assign bus.blank_sec = r_blank_sec;
  assign bus.blank_min = r_blank_min;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a 4-sample debounce: table-driven tick vectors
// plus directed sequences for reset, bounce, clear/pause collisions and adjust mode.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_STOP  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_ADJ   = 2'b11;

  typedef struct {
    logic       t1;
    logic       t2;
    logic       sel;
    logic [5:0] sec;
    logic       expSec;
    logic       expMin;
  } vec_t;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatch;
  int   transitions;
  int   clrCount;
  bit   sawPause;
  bit   sawRun;
  logic [1:0] prevState;
  vec_t runVecs [5];
  vec_t adjVecs [4];
  logic expBlink [3];

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps while tracking state changes and clear pulses for the multi-cycle checks.
  task automatic stepMon(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.state_o != prevState) transitions++;
      if (bus.state_o == S_PAUSE) sawPause = 1'b1;
      if (bus.state_o == S_RUN) sawRun = 1'b1;
      if (bus.clr) clrCount++;
      prevState = bus.state_o;
    end
  endtask

  task automatic resetMon();
    transitions = 0;
    clrCount    = 0;
    sawPause    = 1'b0;
    sawRun      = 1'b0;
    prevState   = bus.state_o;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    bus.sw_sel  = v.sel;
    bus.sec_val = v.sec;
    step(3);
    bus.tick_1hz = v.t1;
    bus.tick_2hz = v.t2;
    step(1);
    bus.tick_1hz = 1'b0;
    bus.tick_2hz = 1'b0;
    checkOutput({tag, " inc_sec"}, 8'(bus.inc_sec), 8'(v.expSec));
    checkOutput({tag, " inc_min"}, 8'(bus.inc_min), 8'(v.expMin));
  endtask

  task automatic pressPause();
    bus.btn_pause = 1'b1;
    step(8);
    bus.btn_pause = 1'b0;
  endtask

  initial begin
    nCompared = 0;
    nMismatch = 0;
    runVecs[0] = '{t1: 1'b1, t2: 1'b0, sel: 1'b0, sec: 6'd58, expSec: 1'b1, expMin: 1'b0};
    runVecs[1] = '{t1: 1'b1, t2: 1'b0, sel: 1'b0, sec: 6'd59, expSec: 1'b1, expMin: 1'b1};
    runVecs[2] = '{t1: 1'b0, t2: 1'b0, sel: 1'b0, sec: 6'd59, expSec: 1'b0, expMin: 1'b0};
    runVecs[3] = '{t1: 1'b0, t2: 1'b1, sel: 1'b1, sec: 6'd59, expSec: 1'b0, expMin: 1'b0};
    runVecs[4] = '{t1: 1'b1, t2: 1'b0, sel: 1'b0, sec: 6'd0,  expSec: 1'b1, expMin: 1'b0};
    adjVecs[0] = '{t1: 1'b0, t2: 1'b1, sel: 1'b0, sec: 6'd59, expSec: 1'b0, expMin: 1'b1};
    adjVecs[1] = '{t1: 1'b0, t2: 1'b1, sel: 1'b1, sec: 6'd59, expSec: 1'b1, expMin: 1'b0};
    adjVecs[2] = '{t1: 1'b1, t2: 1'b0, sel: 1'b1, sec: 6'd59, expSec: 1'b0, expMin: 1'b0};
    adjVecs[3] = '{t1: 1'b0, t2: 1'b1, sel: 1'b1, sec: 6'd30, expSec: 1'b1, expMin: 1'b0};
    expBlink[0] = 1'b1;
    expBlink[1] = 1'b0;
    expBlink[2] = 1'b1;

    rst            = 1'b0;
    bus.btn_pause  = 1'b0;
    bus.btn_rst    = 1'b0;
    bus.sw_adj     = 1'b0;
    bus.sw_sel     = 1'b0;
    bus.tick_1hz   = 1'b0;
    bus.tick_2hz   = 1'b0;
    bus.tick_blink = 1'b0;
    bus.sec_val    = 6'd0;
    step(3);
    checkOutput("reset state", 8'(bus.state_o), 8'(S_STOP));
    checkOutput("reset hold", 8'(bus.hold), 8'd1);
    checkOutput("reset clr", 8'(bus.clr), 8'd0);
    checkOutput("reset inc_sec", 8'(bus.inc_sec), 8'd0);
    checkOutput("reset inc_min", 8'(bus.inc_min), 8'd0);
    checkOutput("reset blank_sec", 8'(bus.blank_sec), 8'd0);
    checkOutput("reset blank_min", 8'(bus.blank_min), 8'd0);

    @(negedge clk);
    rst = 1'b1;
    bus.tick_1hz = 1'b1;
    step(1);
    bus.tick_1hz = 1'b0;
    checkOutput("stop tick inc_sec", 8'(bus.inc_sec), 8'd0);
    step(2);

    $display("[TB] start and carry");
    pressPause();
    checkOutput("start state", 8'(bus.state_o), 8'(S_RUN));
    checkOutput("start hold", 8'(bus.hold), 8'd0);
    step(10);
    checkOutput("release no event", 8'(bus.state_o), 8'(S_RUN));
    for (int i = 0; i < 5; i++) applyStimulus(runVecs[i], $sformatf("run vec %0d", i));

    $display("[TB] asynchronous reset mid-run");
    bus.tick_1hz = 1'b1;
    step(1);
    bus.tick_1hz = 1'b0;
    checkOutput("pre-reset inc_sec", 8'(bus.inc_sec), 8'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset state", 8'(bus.state_o), 8'(S_STOP));
    checkOutput("async reset hold", 8'(bus.hold), 8'd1);
    checkOutput("async reset inc_sec", 8'(bus.inc_sec), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.tick_1hz = 1'b1;
    step(1);
    bus.tick_1hz = 1'b0;
    checkOutput("post-reset tick inc_sec", 8'(bus.inc_sec), 8'd0);
    checkOutput("post-reset state", 8'(bus.state_o), 8'(S_STOP));
    step(2);

    $display("[TB] bounce");
    resetMon();
    for (int i = 0; i < 10; i++) begin
      bus.btn_pause = (i % 2 == 0);
      stepMon(2);
    end
    bus.btn_pause = 1'b1;
    stepMon(15);
    checkOutput("bounce transitions", 8'(transitions), 8'd1);
    checkOutput("bounce no pause glitch", 8'(sawPause), 8'd0);
    checkOutput("bounce final state", 8'(bus.state_o), 8'(S_RUN));
    bus.btn_pause = 1'b0;
    step(10);

    $display("[TB] pause and clear");
    pressPause();
    checkOutput("pause state", 8'(bus.state_o), 8'(S_PAUSE));
    checkOutput("pause hold", 8'(bus.hold), 8'd1);
    step(10);
    bus.sec_val  = 6'd59;
    bus.tick_1hz = 1'b1;
    step(1);
    bus.tick_1hz = 1'b0;
    checkOutput("pause tick1 inc_sec", 8'(bus.inc_sec), 8'd0);
    checkOutput("pause tick1 inc_min", 8'(bus.inc_min), 8'd0);
    bus.tick_2hz = 1'b1;
    step(1);
    bus.tick_2hz = 1'b0;
    checkOutput("pause tick2 inc_sec", 8'(bus.inc_sec), 8'd0);
    checkOutput("pause tick2 inc_min", 8'(bus.inc_min), 8'd0);
    resetMon();
    bus.btn_pause = 1'b1;
    bus.btn_rst   = 1'b1;
    stepMon(12);
    checkOutput("both clr pulses", 8'(clrCount), 8'd1);
    checkOutput("both no run", 8'(sawRun), 8'd0);
    checkOutput("both final state", 8'(bus.state_o), 8'(S_STOP));
    bus.btn_pause = 1'b0;
    bus.btn_rst   = 1'b0;
    step(10);

    $display("[TB] adjust");
    bus.sw_sel = 1'b0;
    bus.sw_adj = 1'b1;
    step(5);
    checkOutput("adj state", 8'(bus.state_o), 8'(S_ADJ));
    checkOutput("adj entry blank_min", 8'(bus.blank_min), 8'd0);
    for (int i = 0; i < 3; i++) begin
      bus.tick_blink = 1'b1;
      step(1);
      bus.tick_blink = 1'b0;
      checkOutput($sformatf("blink %0d blank_min", i), 8'(bus.blank_min), 8'(expBlink[i]));
      checkOutput($sformatf("blink %0d blank_sec", i), 8'(bus.blank_sec), 8'd0);
      step(1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(adjVecs[i], $sformatf("adj vec %0d", i));
    checkOutput("adj sel1 blank_sec", 8'(bus.blank_sec), 8'd1);
    checkOutput("adj sel1 blank_min", 8'(bus.blank_min), 8'd0);
    bus.sw_adj = 1'b0;
    step(5);
    checkOutput("adj exit state", 8'(bus.state_o), 8'(S_PAUSE));
    checkOutput("adj exit blank_sec", 8'(bus.blank_sec), 8'd0);
    checkOutput("adj exit blank_min", 8'(bus.blank_min), 8'd0);

    $display("[TB] tick and clear collision");
    pressPause();
    checkOutput("collision pre state", 8'(bus.state_o), 8'(S_RUN));
    step(10);
    bus.sec_val = 6'd59;
    bus.btn_rst = 1'b1;
    step(6);
    bus.tick_1hz = 1'b1;
    step(1);
    bus.tick_1hz = 1'b0;
    checkOutput("collision clr", 8'(bus.clr), 8'd1);
    checkOutput("collision inc_sec", 8'(bus.inc_sec), 8'd0);
    checkOutput("collision inc_min", 8'(bus.inc_min), 8'd0);
    checkOutput("collision state", 8'(bus.state_o), 8'(S_STOP));
    step(1);
    checkOutput("collision clr one cycle", 8'(bus.clr), 8'd0);
    bus.btn_rst = 1'b0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
